spi_flash_xip_apb: RTL and testbench

//  APB slave that bridges CPU reads in the flash window to an SPI NOR flash (mode 0, read
//  cmd + 24-bit addr + 32 data bits) with a built-in SPI master, no external SPI core.

---
 rtl/spi_flash_pkg.sv | 27 ++
 rtl/spi_flash_shifter.sv | 60 ++++++
 rtl/spi_flash_xip_apb.sv | 198 +++++++++++++++++++
 tb/tb_spi_flash_xip_apb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash XIP APB bridge.
// State encoding, register offsets, default read opcode and frame geometry.
package spi_flash_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_DONE
   } flash_state_t;

   localparam logic [1:0] REG_DIV     = 2'd0;
   localparam logic [1:0] REG_CMD     = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_INVALID = 2'd3;

   localparam logic [7:0] CMD_READ     = 8'h03;
   localparam int         FRAME_BITS   = 64;
   localparam int         HALF_PERIODS = 2 * FRAME_BITS;

   // The first byte received lands in the top of the shift register but belongs in prdata[7:0].
   function automatic logic [31:0] byte_swap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/spi_flash_shifter.sv
// SPI mode-0 shift engine: divided SCK, 64-bit MSB-first transmit, MISO capture.
// A start pulse loads the frame; done pulses in the cycle of the final falling SCK edge.
module spi_flash_shifter
   import spi_flash_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            div,
   input  logic [FRAME_BITS-1:0] tx,
   input  logic                  miso,
   output logic                  sck,
   output logic                  mosi,
   output logic                  done,
   output logic [31:0]           rx
);

   logic                  active;
   logic [7:0]            half_cnt;
   logic [7:0]            edge_cnt;
   logic [FRAME_BITS-1:0] shift_reg;
   logic                  toggle;

   assign toggle = active && (half_cnt == div);
   assign done   = toggle && (edge_cnt == 8'(HALF_PERIODS - 1));
   assign mosi   = shift_reg[FRAME_BITS-1];

   // Rising edges sample MISO; falling edges advance MOSI so it is stable before the next rise.
   always_ff @(posedge clock) begin
      if (reset) begin
         active    <= 1'b0;
         sck       <= 1'b0;
         half_cnt  <= '0;
         edge_cnt  <= '0;
         shift_reg <= '1;
         rx        <= '0;
      end else if (start) begin
         active    <= 1'b1;
         sck       <= 1'b0;
         half_cnt  <= '0;
         edge_cnt  <= '0;
         shift_reg <= tx;
      end else if (active) begin
         if (toggle) begin
            half_cnt <= '0;
            sck      <= ~sck;
            edge_cnt <= edge_cnt + 8'd1;
            if (!sck)
               rx <= {rx[30:0], miso};
            else
               shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b1};
            if (done)
               active <= 1'b0;
         end else begin
            half_cnt <= half_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/spi_flash_xip_apb.sv
// APB slave mapping a flash window onto SPI NOR reads, plus DIV/CMD/STATUS registers.
// Optional one-word read line buffer enabled by defining XIP_LINEBUF_EN.
module spi_flash_xip_apb
   import spi_flash_pkg::*;
#(
   parameter logic [31:0] flash_addr_start = 32'h30000000,
   parameter logic [31:0] flash_addr_end   = 32'h3fffffff,
   parameter int          spi_ss_num       = 8,
   parameter int          FLASH_SS_IDX     = 0,
   parameter logic [7:0]  DIV_RESET        = 8'd1
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           in_paddr,
   input  logic                  in_psel,
   input  logic                  in_penable,
   input  logic [2:0]            in_pprot,
   input  logic                  in_pwrite,
   input  logic [31:0]           in_pwdata,
   input  logic [3:0]            in_pstrb,
   output logic                  in_pready,
   output logic [31:0]           in_prdata,
   output logic                  in_pslverr,
   output logic                  spi_sck,
   output logic [spi_ss_num-1:0] spi_ss,
   output logic                  spi_mosi,
   input  logic                  spi_miso,
   output logic                  spi_irq_out
);

   flash_state_t          state;
   logic [7:0]            div_q, cmd_q, div_l, cmd_l, cnt;
   logic [23:0]           addr_l;
   logic                  irq_q, pready_q;
   logic [31:0]           prdata_q, reg_rdata;
   logic [spi_ss_num-1:0] ss_q;
   logic                  access, in_window, reg_acc, reg_wr, flash_wr, rd_req;
   logic [1:0]            reg_off;
   logic                  sh_start, sh_done, sh_mosi, sh_sck;
   logic [31:0]           sh_rx;
   logic                  lb_hit;
   logic [31:0]           lb_data;
   logic                  unused_bits;

   assign unused_bits = ^{in_pprot, in_pstrb[3:1], in_pwdata[31:8], in_paddr[1:0]};

   assign access    = in_psel && in_penable && !reset;
   assign in_window = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);
   assign reg_off   = in_paddr[3:2];
   assign reg_acc   = access && !in_window;
   assign reg_wr    = reg_acc && in_pwrite;
   assign flash_wr  = access && in_window && in_pwrite;
   assign rd_req    = access && in_window && !in_pwrite && (state == ST_IDLE);

   always_comb begin
      reg_rdata = '0;
      case (reg_off)
         REG_DIV:    reg_rdata = {24'd0, div_q};
         REG_CMD:    reg_rdata = {24'd0, cmd_q};
         REG_STATUS: reg_rdata = {30'd0, irq_q, state != ST_IDLE};
         default:    reg_rdata = '0;
      endcase
   end

   // Register and flash-write responses are zero-wait; flash reads finish through pready_q.
   assign in_pready   = reg_acc || flash_wr || pready_q;
   assign in_pslverr  = (reg_acc && reg_off == REG_INVALID) || flash_wr;
   assign in_prdata   = reg_acc ? reg_rdata : prdata_q;
   assign spi_ss      = ss_q;
   assign spi_sck     = sh_sck;
   assign spi_irq_out = irq_q;
   assign spi_mosi    = (state == ST_SETUP) ? cmd_l[7] :
                        (state == ST_SHIFT) ? sh_mosi  : 1'b1;

   // Configuration registers; byte 0 strobe gates every write.
   always_ff @(posedge clock) begin
      if (reset) begin
         div_q <= DIV_RESET;
         cmd_q <= CMD_READ;
         irq_q <= 1'b0;
      end else begin
         if (reg_wr && in_pstrb[0]) begin
            case (reg_off)
               REG_DIV: div_q <= in_pwdata[7:0];
               REG_CMD: cmd_q <= in_pwdata[7:0];
               default: ;
            endcase
         end
         if (flash_wr)
            irq_q <= 1'b1;
         else if (reg_wr && in_pstrb[0] && reg_off == REG_STATUS && in_pwdata[1])
            irq_q <= 1'b0;
      end
   end

`ifdef XIP_LINEBUF_EN
   logic        lb_valid;
   logic [21:0] lb_addr;

   assign lb_hit = lb_valid && (lb_addr == in_paddr[23:2]);

   // Any DIV/CMD write may change what the flash returns, so the cached word is dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         lb_valid <= 1'b0;
         lb_addr  <= '0;
         lb_data  <= '0;
      end else if (reg_wr && (reg_off == REG_DIV || reg_off == REG_CMD)) begin
         lb_valid <= 1'b0;
      end else if (state == ST_HOLD && cnt == div_l) begin
         lb_valid <= 1'b1;
         lb_addr  <= addr_l[23:2];
         lb_data  <= byte_swap(sh_rx);
      end
   end
`else
   assign lb_hit  = 1'b0;
   assign lb_data = '0;
`endif

   assign sh_start = (state == ST_SETUP) && (cnt == div_l);

   // Read sequencer: DIV and CMD are snapshotted at request time so mid-read writes do not disturb it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         ss_q     <= '1;
         pready_q <= 1'b0;
         prdata_q <= '0;
         div_l    <= '0;
         cmd_l    <= CMD_READ;
         addr_l   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rd_req) begin
                  if (lb_hit) begin
                     state    <= ST_DONE;
                     pready_q <= 1'b1;
                     prdata_q <= lb_data;
                  end else begin
                     state              <= ST_SETUP;
                     cnt                <= '0;
                     ss_q[FLASH_SS_IDX] <= 1'b0;
                     div_l              <= div_q;
                     cmd_l              <= cmd_q;
                     addr_l             <= {in_paddr[23:2], 2'b00};
                  end
               end
            end
            ST_SETUP: begin
               if (cnt == div_l) begin
                  state <= ST_SHIFT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_SHIFT: begin
               if (sh_done) begin
                  state <= ST_HOLD;
                  cnt   <= '0;
               end
            end
            ST_HOLD: begin
               if (cnt == div_l) begin
                  state    <= ST_DONE;
                  ss_q     <= '1;
                  pready_q <= 1'b1;
                  prdata_q <= byte_swap(sh_rx);
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_DONE: begin
               pready_q <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   spi_flash_shifter u_shifter (
      .clock (clock),
      .reset (reset),
      .start (sh_start),
      .div   (div_l),
      .tx    ({cmd_l, addr_l, 32'hFFFF_FFFF}),
      .miso  (spi_miso),
      .sck   (sh_sck),
      .mosi  (sh_mosi),
      .done  (sh_done),
      .rx    (sh_rx)
   );

endmodule

// File: tb/tb_spi_flash_xip_apb.sv
// Directed bench for spi_flash_xip_apb with a behavioural mode-0 SPI flash slave.
// Line-buffer checks are compiled in when XIP_LINEBUF_EN is defined.
module tb_spi_flash_xip_apb;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_paddr = '0;
   logic        in_psel = 1'b0;
   logic        in_penable = 1'b0;
   logic [2:0]  in_pprot = '0;
   logic        in_pwrite = 1'b0;
   logic [31:0] in_pwdata = '0;
   logic [3:0]  in_pstrb = '0;
   logic        in_pready;
   logic [31:0] in_prdata;
   logic        in_pslverr;
   logic        spi_sck;
   logic [7:0]  spi_ss;
   logic        spi_mosi;
   logic        spi_miso = 1'b0;
   logic        spi_irq_out;

   int test_count = 0;
   int fail_count = 0;

   always #5 clock = ~clock;

   spi_flash_xip_apb dut (
      .clock       (clock),
      .reset       (reset),
      .in_paddr    (in_paddr),
      .in_psel     (in_psel),
      .in_penable  (in_penable),
      .in_pprot    (in_pprot),
      .in_pwrite   (in_pwrite),
      .in_pwdata   (in_pwdata),
      .in_pstrb    (in_pstrb),
      .in_pready   (in_pready),
      .in_prdata   (in_prdata),
      .in_pslverr  (in_pslverr),
      .spi_sck     (spi_sck),
      .spi_ss      (spi_ss),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_irq_out (spi_irq_out)
   );

   // Flash slave: word bytes streamed MSB-first starting with the top byte of flash_word.
   logic [31:0] flash_word = 32'h11223344;
   logic [31:0] mosi_word = '0;
   logic        prev_sck = 1'b0;
   int rise_cnt = 0, total_rises = 0, ss_low_cycles = 0;
   int high_run = 0, last_high_run = 0, data_mosi_zero = 0;

   always @(negedge clock) begin
      if (spi_sck && !prev_sck) begin
         total_rises++;
         if (!spi_ss[0]) begin
            if (rise_cnt < 32) mosi_word = {mosi_word[30:0], spi_mosi};
            else if (!spi_mosi) data_mosi_zero++;
            rise_cnt++;
         end
      end
      if (!spi_sck && prev_sck && rise_cnt >= 32 && rise_cnt < 64)
         spi_miso = flash_word[63-rise_cnt];
      if (spi_sck) high_run++;
      else begin
         if (prev_sck) last_high_run = high_run;
         high_run = 0;
      end
      if (!spi_ss[0]) ss_low_cycles++;
      else rise_cnt = 0;
      prev_sck = spi_sck;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      test_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One APB transfer; cycles counts from the first access-phase cycle to the pready cycle.
   task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                                output int cycles, output logic next_pready);
      @(posedge clock); #1;
      in_psel = 1'b1; in_penable = 1'b0; in_pwrite = write;
      in_paddr = addr; in_pwdata = wdata; in_pstrb = strb;
      @(posedge clock); #1;
      in_penable = 1'b1;
      cycles = 0;
      #5;
      while (!in_pready && cycles < 2000) begin
         @(posedge clock); #6;
         cycles++;
      end
      if (!in_pready) checkOutput("apb_timeout", {31'd0, in_pready}, 32'd1);
      rdata = in_prdata;
      err   = in_pslverr;
      @(posedge clock); #1;
      in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
      #5;
      next_pready = in_pready;
   endtask

   initial begin
      logic [31:0] rd;
      logic        err, np, seen;
      int          cyc, r0, s0, z0;

      repeat (2) @(posedge clock);
      #6;
      checkOutput("reset_pready",  {31'd0, in_pready},   32'd0);
      checkOutput("reset_pslverr", {31'd0, in_pslverr},  32'd0);
      checkOutput("reset_prdata",  in_prdata,            32'd0);
      checkOutput("reset_ss",      {24'd0, spi_ss},      32'hFF);
      checkOutput("reset_sck",     {31'd0, spi_sck},     32'd0);
      checkOutput("reset_mosi",    {31'd0, spi_mosi},    32'd1);
      checkOutput("reset_irq",     {31'd0, spi_irq_out}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("div_reset", rd, 32'd1);
      checkOutput("div_read_wait", cyc, 32'd0);
      applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("cmd_reset", rd, 32'h03);
      checkOutput("cmd_read_err", {31'd0, err}, 32'd0);

      // DIV=0 read of 0x30000004
      applyStimulus(1'b1, 32'h0, 32'h0, 4'h1, rd, err, cyc, np);
      flash_word = 32'h11223344;
      r0 = total_rises; s0 = ss_low_cycles; z0 = data_mosi_zero;
      applyStimulus(1'b0, 32'h30000004, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("rd0_data",      rd, 32'h44332211);
      checkOutput("rd0_latency",   cyc, 32'd131);
      checkOutput("rd0_err",       {31'd0, err}, 32'd0);
      checkOutput("rd0_one_cycle", {31'd0, np}, 32'd0);
      checkOutput("rd0_mosi",      mosi_word, 32'h03000004);
      checkOutput("rd0_rises",     total_rises - r0, 32'd64);
      checkOutput("rd0_ss_low",    ss_low_cycles - s0, 32'd130);
      checkOutput("rd0_mosi_data", data_mosi_zero - z0, 32'd0);
      checkOutput("rd0_ss_idle",   {24'd0, spi_ss}, 32'hFF);

      // DIV=3: half period of 4 clocks
      applyStimulus(1'b1, 32'h0, 32'h3, 4'h1, rd, err, cyc, np);
      flash_word = 32'hA1B2C3D4;
      applyStimulus(1'b0, 32'h30ABCDEC, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("rd3_data",    rd, 32'hD4C3B2A1);
      checkOutput("rd3_latency", cyc, 32'd521);
      checkOutput("rd3_sck_hi",  last_high_run, 32'd4);
      checkOutput("rd3_mosi",    mosi_word, 32'h03ABCDEC);

      // Flash write is an error with no SPI activity
      r0 = total_rises;
      applyStimulus(1'b1, 32'h30000000, 32'hDEADBEEF, 4'hF, rd, err, cyc, np);
      checkOutput("fw_wait",   cyc, 32'd0);
      checkOutput("fw_err",    {31'd0, err}, 32'd1);
      checkOutput("fw_no_sck", total_rises - r0, 32'd0);
      checkOutput("fw_irq",    {31'd0, spi_irq_out}, 32'd1);
      applyStimulus(1'b0, 32'h8, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("status_irq", rd, 32'h2);
      applyStimulus(1'b1, 32'h8, 32'h2, 4'h1, rd, err, cyc, np);
      checkOutput("irq_clear", {31'd0, spi_irq_out}, 32'd0);

      applyStimulus(1'b0, 32'hC, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("off_c_err",  {31'd0, err}, 32'd1);
      checkOutput("off_c_wait", cyc, 32'd0);

      applyStimulus(1'b1, 32'h4, 32'h0B, 4'h0, rd, err, cyc, np);
      applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("cmd_no_strb", rd, 32'h03);
      applyStimulus(1'b1, 32'h4, 32'h0B, 4'h1, rd, err, cyc, np);
      applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("cmd_strb", rd, 32'h0B);

      // Reset asserted in cycle T0+40 of a DIV=3 read
      @(posedge clock); #1;
      in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b0; in_paddr = 32'h30000008;
      @(posedge clock); #1;
      in_penable = 1'b1;
      repeat (40) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0; in_psel = 1'b0; in_penable = 1'b0;
      #5;
      checkOutput("abort_ss",     {24'd0, spi_ss}, 32'hFF);
      checkOutput("abort_sck",    {31'd0, spi_sck}, 32'd0);
      checkOutput("abort_pready", {31'd0, in_pready}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clock); #6;
         if (in_pready || !spi_ss[0]) seen = 1'b1;
      end
      checkOutput("abort_quiet", {31'd0, seen}, 32'd0);
      applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("abort_cmd_reset", rd, 32'h03);
      flash_word = 32'h55667788;
      applyStimulus(1'b0, 32'h30000008, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("post_abort_data",    rd, 32'h88776655);
      checkOutput("post_abort_latency", cyc, 32'd261);
      checkOutput("post_abort_mosi",    mosi_word, 32'h03000008);

      // Repeat read of the same word, then after a DIV write
      applyStimulus(1'b1, 32'h0, 32'h0, 4'h1, rd, err, cyc, np);
      flash_word = 32'h0A0B0C0D;
      applyStimulus(1'b0, 32'h30000010, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("lb_first_data", rd, 32'h0D0C0B0A);
      checkOutput("lb_first_lat",  cyc, 32'd131);
      r0 = total_rises;
      applyStimulus(1'b0, 32'h30000010, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("lb_second_data", rd, 32'h0D0C0B0A);
`ifdef XIP_LINEBUF_EN
      checkOutput("lb_hit_lat",    cyc, 32'd1);
      checkOutput("lb_hit_no_sck", total_rises - r0, 32'd0);
      checkOutput("lb_hit_once",   {31'd0, np}, 32'd0);
`else
      checkOutput("nolb_second_lat", cyc, 32'd131);
`endif
      applyStimulus(1'b1, 32'h0, 32'h0, 4'h1, rd, err, cyc, np);
      r0 = total_rises;
      applyStimulus(1'b0, 32'h30000010, 32'h0, 4'h0, rd, err, cyc, np);
      checkOutput("lb_inval_lat",   cyc, 32'd131);
      checkOutput("lb_inval_rises", total_rises - r0, 32'd64);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
